motoro3_pwm_capture: RTL

- Receive-side counterpart of the motor PWM generator. Samples a PWM waveform, either looped back from the gate-drive pin or taken directly from the generator output.
- Per PWM frame (rising edge to rising edge), measures high time and period.
- Per commutation step, accumulates total high cycles and counts short pulses below the minimum MOS-open width.
- Results feed the position-loss bookkeeping and the debug register block.

---
 rtl/motoro3_pwm_capture_if.sv | 33 +++
 rtl/motoro3_pwm_capture.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_capture_if.sv
// Signal bundle for motoro3_pwm_capture: PWM input and capture controls in,
// frame and commutation-step results out.
interface motoro3_pwm_capture_if #(
  parameter int CNT_W = 12,
  parameter int ACC_W = 16,
  parameter int SPC_W = 8
);
  logic             pwmIn;
  logic             capEnable;
  logic             m3cntLast2;
  logic [3:0]       sgStep;
  logic [11:0]      m3r_pwmMinMask;
  logic [CNT_W-1:0] frmHigh;
  logic [CNT_W-1:0] frmPeriod;
  logic             frmValid;
  logic             frmTimeout;
  logic [ACC_W-1:0] stepHigh;
  logic [3:0]       stepId;
  logic [SPC_W-1:0] stepShort;
  logic             stepValid;

  modport master (
    output pwmIn, capEnable, m3cntLast2, sgStep, m3r_pwmMinMask,
    input  frmHigh, frmPeriod, frmValid, frmTimeout,
           stepHigh, stepId, stepShort, stepValid
  );

  modport slave (
    input  pwmIn, capEnable, m3cntLast2, sgStep, m3r_pwmMinMask,
    output frmHigh, frmPeriod, frmValid, frmTimeout,
           stepHigh, stepId, stepShort, stepValid
  );
endinterface

// File: rtl/motoro3_pwm_capture.sv
// PWM capture: per-frame high/period measurement and per-step high-cycle / short-pulse stats.
// Optional MOTORO3_PWM_CAP_GLITCH_EN inserts a 3-sample majority filter after the synchronizer.
module motoro3_pwm_capture #(
  parameter int CNT_W = 12,
  parameter int ACC_W = 16,
  parameter int SPC_W = 8
) (
  input  logic                  clk,
  input  logic                  nRst,
  motoro3_pwm_capture_if.slave  cap
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [SPC_W-1:0] SPC_MAX = '1;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, pwm_dly_q;
  logic             pwm_s, rise, fall;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [CNT_W-1:0] frm_high_q, frm_high_d, frm_per_q, frm_per_d;
  logic [ACC_W-1:0] acc_q, acc_d, step_high_q, step_high_d;
  logic [SPC_W-1:0] short_q, short_d, step_short_q, step_short_d;
  logic [3:0]       step_id_q, step_id_d;
  logic             frm_vld_q, frm_vld_d, tmo_q, tmo_d, step_vld_q, step_vld_d;
  logic             sat_ev, short_ev;

  // Everything in this block advances on the falling edge of clk.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) {sync2_q, sync1_q} <= '0;
    else       {sync2_q, sync1_q} <= {sync1_q, cap.pwmIn};
  end

`ifdef MOTORO3_PWM_CAP_GLITCH_EN
  logic sync3_q, sync4_q;
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) {sync4_q, sync3_q} <= '0;
    else       {sync4_q, sync3_q} <= {sync3_q, sync2_q};
  end
  assign pwm_s = (sync2_q & sync3_q) | (sync2_q & sync4_q) | (sync3_q & sync4_q);
`else
  assign pwm_s = sync2_q;
`endif

  assign rise = pwm_s & ~pwm_dly_q;
  assign fall = ~pwm_s & pwm_dly_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    per_d        = per_q;
    acc_d        = acc_q;
    short_d      = short_q;
    frm_high_d   = frm_high_q;
    frm_per_d    = frm_per_q;
    frm_vld_d    = 1'b0;
    tmo_d        = tmo_q;
    step_high_d  = step_high_q;
    step_short_d = step_short_q;
    step_id_d    = step_id_q;
    step_vld_d   = 1'b0;
    sat_ev       = 1'b0;
    short_ev     = 1'b0;

    if (!cap.capEnable) begin
      state_d = IDLE;
    end else begin
      if (pwm_s && acc_q != ACC_MAX) acc_d = acc_q + ACC_W'(1);
      case (state_q)
        IDLE: if (rise) begin
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
          state_d = HIGH;
        end
        HIGH: if (per_q == CNT_MAX) begin
          state_d = IDLE;
          sat_ev  = 1'b1;
        end else begin
          per_d = per_q + CNT_W'(1);
          if (fall) begin
            // hiCnt already holds the full high width on the fall cycle
            state_d  = LOW;
            short_ev = (cap.m3r_pwmMinMask != '0) &&
                       (32'(hi_q) < 32'(cap.m3r_pwmMinMask));
          end else if (hi_q != CNT_MAX) begin
            hi_d = hi_q + CNT_W'(1);
          end
        end
        LOW: if (rise) begin
          frm_high_d = hi_q;
          frm_per_d  = per_q;
          frm_vld_d  = 1'b1;
          hi_d       = CNT_W'(1);
          per_d      = CNT_W'(1);
          state_d    = HIGH;
        end else if (per_q == CNT_MAX) begin
          state_d = IDLE;
          sat_ev  = 1'b1;
        end else begin
          per_d = per_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (short_ev && short_q != SPC_MAX) short_d = short_q + SPC_W'(1);
      if (sat_ev) tmo_d = 1'b1;
    end

    // Step boundary snapshots pre-update values; events of this cycle seed the next step.
    if (cap.m3cntLast2) begin
      step_high_d  = acc_q;
      step_short_d = short_q;
      step_id_d    = cap.sgStep;
      step_vld_d   = 1'b1;
      acc_d        = cap.capEnable ? ACC_W'(pwm_s) : '0;
      short_d      = short_ev ? SPC_W'(1) : '0;
      tmo_d        = sat_ev;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      pwm_dly_q    <= 1'b0;
      hi_q         <= '0;
      per_q        <= '0;
      acc_q        <= '0;
      short_q      <= '0;
      frm_high_q   <= '0;
      frm_per_q    <= '0;
      frm_vld_q    <= 1'b0;
      tmo_q        <= 1'b0;
      step_high_q  <= '0;
      step_short_q <= '0;
      step_id_q    <= '0;
      step_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_dly_q    <= pwm_s;
      hi_q         <= hi_d;
      per_q        <= per_d;
      acc_q        <= acc_d;
      short_q      <= short_d;
      frm_high_q   <= frm_high_d;
      frm_per_q    <= frm_per_d;
      frm_vld_q    <= frm_vld_d;
      tmo_q        <= tmo_d;
      step_high_q  <= step_high_d;
      step_short_q <= step_short_d;
      step_id_q    <= step_id_d;
      step_vld_q   <= step_vld_d;
    end
  end

  assign cap.frmHigh    = frm_high_q;
  assign cap.frmPeriod  = frm_per_q;
  assign cap.frmValid   = frm_vld_q;
  assign cap.frmTimeout = tmo_q;
  assign cap.stepHigh   = step_high_q;
  assign cap.stepId     = step_id_q;
  assign cap.stepShort  = step_short_q;
  assign cap.stepValid  = step_vld_q;
endmodule
